vga_mode_sequencer: RTL and testbench
=====================================

# vga_mode_sequencer

Parametrised register slave and mode-switch sequencer for the VGA subsystem. It holds display configuration (mode, cursor, framebuffer base) behind a Wishbone slave port. It selects one of `NUM_MODES` mode drivers, and switches between them safely. A switch happens only after the outgoing driver has drained its outstanding master cycle and every driver has been held in reset for a programmable interval. The parent display block uses `mode_sel_o` to mux pixel, sync and master-bus signals.

## Interface
Parameters:
- `NUM_MODES`, 6: number of mode drivers, 2..16.
- `MODE_W`, 4: width of the mode field; `NUM_MODES` ≤ 2^`MODE_W`.
- `DEFAULT_MODE`, 5: mode active after reset; must be < `NUM_MODES`.
- `RST_CYCLES`, 4: cycles all drivers are held in reset during a switch, ≥ 1.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_n`, in, 1: reset, **synchronous, active-low**.
- `inbus`, `if_wb.slave`, 32-bit data: register port; `adr[4:2]` selects the register.
- `vs_i`, in, 1: vertical sync of the active driver, synchronous to `clk_i`, active-low.
- `mode_busy_i`, in, `NUM_MODES`: per-driver flag, high while that driver has a master cycle in flight.
- `mode_sel_o`, out, `MODE_W`: active mode index.
- `mode_rst_o`, out, `NUM_MODES`: per-driver reset, active-high.
- `mode_hold_o`, out, 1: drivers must not start new master cycles while this is high.
- `cursorpos_o`, out, 32: cursor position.
- `cursormode_o`, out, 4: cursor mode.
- `cursorcolor_o`, out, 24: cursor colour.
- `fbbase_o`, out, 32: framebuffer base byte address.

## Operation
Registers, selected by `adr[4:2]`. All writes honour `sel` byte lanes.
- 0 CTRL: `[MODE_W-1:0]` requested mode, `[11:8]` cursor mode.
- 1 CURPOS.
- 2 CURCOLOR: `[23:0]`; the upper byte reads as 0.
- 3 FBBASE.
- 4 STATUS, read-only:
  - `[MODE_W-1:0]` active mode.
  - `[16]` switch in progress.
  - `[17]` sticky illegal-mode error; a write of 1 clears it.
- 5 FRAMES, read-only: 32-bit count of `vs_i` falling edges; wraps.
- 6..7: reads return 0; writes are ignored.

Mode-field write rules:
- A CTRL write with mode ≥ `NUM_MODES` leaves the requested mode unchanged and sets STATUS[17]. The other CTRL fields still update.
- A write whose `sel[0]` is clear leaves the mode field untouched.

Switch FSM states: `MS_RUN`, `MS_WAIT`, `MS_DRAIN`, `MS_RESET`.
- `MS_RUN`:
  - `mode_rst_o` = ~onehot(active); `mode_hold_o` = 0.
  - If requested ≠ active: go to `MS_WAIT` (with `VGA_MODE_VBLANK_SYNC_EN`) or `MS_DRAIN` (without it).
- `MS_WAIT`: hold asserted; leave on the next `vs_i` falling edge.
- `MS_DRAIN`: hold asserted; leave when `mode_busy_i[active]` = 0.
- `MS_RESET`:
  - All `mode_rst_o` are high.
  - On entry, active is loaded from requested.
  - Stay `RST_CYCLES` cycles, then go to `MS_RUN`.
- Requests written during a switch are latched and take effect after the current switch returns to `MS_RUN`. Last write wins.
- A write that sets requested = active while in `MS_RUN` does nothing.

## Timing
- Slave handshake:
  - `inbus.stall` is tied to 0.
  - `ack` is asserted for exactly one cycle, one cycle after `cyc & stb` is sampled.
  - Read data is valid with `ack`.
  - Back-to-back requests are acked on consecutive cycles.
- Registers update on the edge that raises `ack`. The FSM sees a new request one cycle later.
- DRAIN with `mode_busy_i` low: the mode change reaches `mode_sel_o` 2 cycles after the write's ack (RUN→DRAIN, DRAIN→RESET). All resets are high for `RST_CYCLES` cycles, then the new driver's reset drops.
- Reset values (applied while `rst_n` = 0):
  - Requested and active modes = `DEFAULT_MODE`.
  - CURPOS, FBBASE, FRAMES = 0.
  - Cursor mode = 0; cursor colour = 24'ha0a0a0; STATUS[17] = 0.
  - `ack` = 0; `mode_hold_o` = 0; all `mode_rst_o` = 1.
  - State = `MS_RESET` with counter 0, so `DEFAULT_MODE` leaves reset `RST_CYCLES` cycles after `rst_n` rises.
- Reset asserted mid-switch or mid-bus-cycle: the next edge returns everything to the reset values, and no `ack` is issued.
- FRAMES increments on every `vs_i` falling edge, including during a switch.

## Configuration
- `VGA_MODE_VBLANK_SYNC_EN` defined:
  - The `MS_WAIT` state exists, so a switch starts only at the start of vertical sync.
  - A switch requested while `vs_i` is already low waits for the next falling edge.
- Not defined: `MS_WAIT` is omitted, and `MS_RUN` goes directly to `MS_DRAIN`.

## Test plan
- Reset: hold `rst_n` low 3 cycles, then release → `mode_sel_o` = 5, CURCOLOR reads 0x00a0a0a0, `mode_rst_o[5]` drops exactly 4 cycles after release.
- Write CTRL = 0x3 with `mode_busy_i[5]` held high for 10 cycles → `mode_hold_o` high throughout, `mode_sel_o` stays 5 until busy falls, then reads 3 and all resets are high for 4 cycles.
- Write CTRL = 0x9 with `NUM_MODES` = 6 → active mode unchanged, STATUS reads 0x0002_0005; write STATUS = 0x0002_0000 → STATUS[17] = 0.
- Byte-lane write of CURPOS = 0xAABBCCDD with `sel` = 4'b0101 after reset → reads 0x00BB00DD.
- Two writes during a switch (mode 1, then mode 2) → after the first switch completes, a second switch lands on mode 2; mode 1 is never selected.
- With the macro defined, write mode 0 while `vs_i` is high and pulse `vs_i` low 20 cycles later → `mode_sel_o` stays 5 until the falling edge; FRAMES increments by 1.

Source files
------------

// File: rtl/vga_mode_sequencer_if.sv
// Wishbone pipelined bus with 32-bit data, shared by the VGA register slave
// and whoever masters it. adr is a byte address; sel carries byte lanes.
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        stall;

    modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, stall);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, stall);
endinterface

// File: rtl/vga_mode_sequencer.sv
// VGA mode sequencer: Wishbone register slave holding display configuration
// plus a switch FSM that moves between mode drivers safely (hold, drain the
// outgoing driver's master cycle, hold every driver in reset, then release
// the new one). Optional feature macro: VGA_MODE_VBLANK_SYNC_EN -- when
// defined, a switch waits for the next vs_i falling edge before draining.
module vga_mode_sequencer #(
    parameter int NUM_MODES    = 6,
    parameter int MODE_W       = 4,
    parameter int DEFAULT_MODE = 5,
    parameter int RST_CYCLES   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    if_wb.slave                  inbus,
    input  logic                 vs_i,
    input  logic [NUM_MODES-1:0] mode_busy_i,
    output logic [MODE_W-1:0]    mode_sel_o,
    output logic [NUM_MODES-1:0] mode_rst_o,
    output logic                 mode_hold_o,
    output logic [31:0]          cursorpos_o,
    output logic [3:0]           cursormode_o,
    output logic [23:0]          cursorcolor_o,
    output logic [31:0]          fbbase_o
);
    localparam int                CNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_DEF = MODE_W'(DEFAULT_MODE);
    // One bit wider than the mode field so NUM_MODES == 2^MODE_W still compares correctly.
    localparam logic [MODE_W:0]   MODE_LIM = (MODE_W + 1)'(NUM_MODES);

`ifdef VGA_MODE_VBLANK_SYNC_EN
    typedef enum logic [1:0] {MS_RUN, MS_WAIT, MS_DRAIN, MS_RESET} state_t;
`else
    typedef enum logic [1:0] {MS_RUN, MS_DRAIN, MS_RESET} state_t;
`endif

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   load_active;
    logic [MODE_W-1:0]      active, req;
    logic [NUM_MODES-1:0]   active_onehot;
    logic                   busy_active;
    logic [31:0]            cursorpos, fbbase, frames, rdata, read_mux;
    logic [3:0]             curmode;
    logic [23:0]            curcolor;
    logic                   err, ack, vs_q;

    logic                   bus_req, bus_wr, mode_bad, vs_fall, unused_adr;
    logic [2:0]             reg_idx;
    logic [MODE_W-1:0]      wmode;

    assign bus_req    = inbus.cyc & inbus.stb;
    assign bus_wr     = bus_req & inbus.we;
    assign reg_idx    = inbus.adr[4:2];
    assign wmode      = inbus.dat_w[MODE_W-1:0];
    assign mode_bad   = {1'b0, wmode} >= MODE_LIM;
    assign vs_fall    = vs_q & ~vs_i;
    assign unused_adr = ^{inbus.adr[31:5], inbus.adr[1:0]};

    assign inbus.stall    = 1'b0;
    assign inbus.ack      = ack;
    assign inbus.dat_r    = rdata;
    assign mode_sel_o     = active;
    assign cursorpos_o    = cursorpos;
    assign cursormode_o   = curmode;
    assign cursorcolor_o  = curcolor;
    assign fbbase_o       = fbbase;

    // Register file writes, byte-lane masked; illegal mode requests only raise the sticky error.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            req       <= MODE_DEF;
            cursorpos <= '0;
            curmode   <= '0;
            curcolor  <= 24'ha0a0a0;
            fbbase    <= '0;
            err       <= 1'b0;
        end else if (bus_wr) begin
            case (reg_idx)
                3'd0: begin
                    if (inbus.sel[0]) begin
                        if (mode_bad) err <= 1'b1;
                        else          req <= wmode;
                    end
                    if (inbus.sel[1]) curmode <= inbus.dat_w[11:8];
                end
                3'd1: for (int b = 0; b < 4; b++)
                          if (inbus.sel[b]) cursorpos[8*b +: 8] <= inbus.dat_w[8*b +: 8];
                3'd2: for (int b = 0; b < 3; b++)
                          if (inbus.sel[b]) curcolor[8*b +: 8] <= inbus.dat_w[8*b +: 8];
                3'd3: for (int b = 0; b < 4; b++)
                          if (inbus.sel[b]) fbbase[8*b +: 8] <= inbus.dat_w[8*b +: 8];
                3'd4: if (inbus.sel[2] && inbus.dat_w[17]) err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Read mux over the current register contents.
    always_comb begin
        read_mux = '0;
        case (reg_idx)
            3'd0: begin
                read_mux[MODE_W-1:0] = req;
                read_mux[11:8]       = curmode;
            end
            3'd1: read_mux = cursorpos;
            3'd2: read_mux = {8'h00, curcolor};
            3'd3: read_mux = fbbase;
            3'd4: begin
                read_mux[MODE_W-1:0] = active;
                read_mux[16]         = (state != MS_RUN);
                read_mux[17]         = err;
            end
            3'd5: read_mux = frames;
            default: read_mux = '0;
        endcase
    end

    // Single-cycle ack for every sampled request; read data travels with it.
    always_ff @(posedge clk_i) begin
        if (!rst_n) ack <= 1'b0;
        else        ack <= bus_req;
        if (bus_req) rdata <= read_mux;
    end

    // Frame counter on vs_i falling edges; the edge detector sample is not reset.
    always_ff @(posedge clk_i) begin
        vs_q <= vs_i;
        if (!rst_n)       frames <= '0;
        else if (vs_fall) frames <= frames + 32'd1;
    end

    // Decode the active mode into a one-hot and pick its busy flag.
    always_comb begin
        active_onehot = '0;
        busy_active   = 1'b0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (active == MODE_W'(i)) begin
                active_onehot[i] = 1'b1;
                busy_active      = mode_busy_i[i];
            end
        end
    end

    // Switch FSM state, reset-interval counter and active mode.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state  <= MS_RESET;
            cnt    <= '0;
            active <= MODE_DEF;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_active) active <= req;
        end
    end

    // Switch FSM next state and driver control outputs.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_active = 1'b0;
        mode_hold_o = 1'b0;
        mode_rst_o  = ~active_onehot;
        case (state)
            MS_RUN: begin
                if (req != active) begin
`ifdef VGA_MODE_VBLANK_SYNC_EN
                    state_nxt = MS_WAIT;
`else
                    state_nxt = MS_DRAIN;
`endif
                end
            end
`ifdef VGA_MODE_VBLANK_SYNC_EN
            MS_WAIT: begin
                mode_hold_o = 1'b1;
                if (vs_fall) state_nxt = MS_DRAIN;
            end
`endif
            MS_DRAIN: begin
                mode_hold_o = 1'b1;
                if (!busy_active) begin
                    state_nxt   = MS_RESET;
                    cnt_nxt     = '0;
                    load_active = 1'b1;
                end
            end
            MS_RESET: begin
                mode_rst_o = '1;
                if (cnt == CNT_LAST) state_nxt = MS_RUN;
                else                 cnt_nxt   = cnt + CNT_W'(1);
            end
            default: state_nxt = MS_RESET;
        endcase
    end
endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: a behavioural model of the register file and
// switch sequence checked against the DUT on every falling clock edge, plus
// directed vectors with hand-computed expectations.
module tb_vga_mode_sequencer;
    localparam int NM  = 6;
    localparam int MW  = 4;
    localparam int DEF = 5;
    localparam int RC  = 4;

    logic          clk;
    logic          rst_n;
    logic          vs;
    logic [NM-1:0] busy;
    logic [MW-1:0] sel_o;
    logic [NM-1:0] rst_o;
    logic          hold_o;
    logic [31:0]   curpos_o;
    logic [3:0]    curmode_o;
    logic [23:0]   curcolor_o;
    logic [31:0]   fb_o;

    if_wb wb();

    vga_mode_sequencer #(
        .NUM_MODES(NM), .MODE_W(MW), .DEFAULT_MODE(DEF), .RST_CYCLES(RC)
    ) dut (
        .clk_i(clk), .rst_n(rst_n), .inbus(wb), .vs_i(vs), .mode_busy_i(busy),
        .mode_sel_o(sel_o), .mode_rst_o(rst_o), .mode_hold_o(hold_o),
        .cursorpos_o(curpos_o), .cursormode_o(curmode_o),
        .cursorcolor_o(curcolor_o), .fbbase_o(fb_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what the outputs must be after the most recent rising edge.
    int          m_active, m_req, m_left;
    logic [3:0]  m_curmode;
    logic [31:0] m_curpos, m_color, m_fb, m_frames, m_rdata;
    bit          m_err, m_wait, m_drain, m_ack, m_vs_prev;
    bit          m_live = 1'b0;

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) if (s[b]) mask |= 32'hff << (8 * b);
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return 32'(m_req) | (32'(m_curmode) << 8);
            1: return m_curpos;
            2: return m_color;
            3: return m_fb;
            4: return 32'(m_active) | (32'(m_left > 0 || m_wait || m_drain) << 16) | (32'(m_err) << 17);
            5: return m_frames;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        case (idx)
            0: begin
                if (s[0]) begin
                    if (int'(d[3:0]) >= NM) m_err = 1'b1;
                    else                    m_req = int'(d[3:0]);
                end
                if (s[1]) m_curmode = d[11:8];
            end
            1: m_curpos = lanes(m_curpos, d, s);
            2: m_color  = lanes(m_color, d, s) & 32'h00ff_ffff;
            3: m_fb     = lanes(m_fb, d, s);
            4: if (s[2] && d[17]) m_err = 1'b0;
            default: ;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs the DUT sees.
    always @(posedge clk) begin : model
        bit fall;
        int old_req;
        if (!rst_n) begin
            m_active = DEF; m_req = DEF; m_left = RC;
            m_curmode = '0; m_curpos = '0; m_color = 32'h00a0a0a0; m_fb = '0; m_frames = '0;
            m_err = 1'b0; m_wait = 1'b0; m_drain = 1'b0; m_ack = 1'b0;
            m_live = 1'b1;
        end else begin
            fall    = m_vs_prev && !vs;
            old_req = m_req;
            m_ack   = wb.cyc && wb.stb;
            if (m_ack) begin
                m_rdata = model_read(int'(wb.adr[4:2]));
                if (wb.we) model_write(int'(wb.adr[4:2]), wb.dat_w, wb.sel);
            end
            if (fall) m_frames = m_frames + 32'd1;
            if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (m_drain) begin
                if (!busy[m_active]) begin
                    m_drain = 1'b0; m_left = RC; m_active = old_req;
                end
            end else if (m_wait) begin
                if (fall) begin m_wait = 1'b0; m_drain = 1'b1; end
            end else if (old_req != m_active) begin
`ifdef VGA_MODE_VBLANK_SYNC_EN
                m_wait = 1'b1;
`else
                m_drain = 1'b1;
`endif
            end
        end
        m_vs_prev = vs;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NM-1:0] er;
        er = '1;
        if (m_left == 0) er[m_active] = 1'b0;
        check("m_sel", 32'(sel_o), 32'(m_active));
        check("m_rst", 32'(rst_o), 32'(er));
        check("m_hold", 32'(hold_o), 32'(m_wait || m_drain));
        check("m_curpos", curpos_o, m_curpos);
        check("m_curmode", 32'(curmode_o), 32'(m_curmode));
        check("m_color", 32'(curcolor_o), m_color);
        check("m_fbbase", fb_o, m_fb);
        check("m_ack", 32'(wb.ack), 32'(m_ack));
        if (m_ack) check("m_rdata", wb.dat_r, m_rdata);
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_live) compare_all();
    endtask

    task automatic bus_drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        wb.adr = a; wb.dat_w = d; wb.sel = s; wb.we = w; wb.cyc = 1'b1; wb.stb = 1'b1;
    endtask

    task automatic bus_idle();
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        tick();
        bus_drive(a, d, s, 1'b1);
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        tick();
        bus_drive(a, 32'h0, 4'hf, 1'b0);
        tick();
        d = wb.dat_r;
        bus_idle();
    endtask

    initial begin : stim
        logic [31:0] d;
        bit saw1;
        rst_n = 1'b0; vs = 1'b1; busy = '0;
        wb.adr = '0; wb.dat_w = '0; wb.sel = '0;
        bus_idle();

        // Reset held three cycles, then released.
        repeat (3) tick();
        check("rst_sel", 32'(sel_o), 32'd5);
        check("rst_all_rst", 32'(rst_o), 32'h3f);
        check("rst_hold", 32'(hold_o), 32'd0);
        check("rst_ack", 32'(wb.ack), 32'd0);
        check("stall", 32'(wb.stall), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) check("rst5_held", 32'(rst_o[5]), 32'd1);
            else       check("rst5_drop", 32'(rst_o[5]), 32'd0);
        end

        // Register defaults and unused addresses.
        rd(32'h08, d); check("curcolor_rst", d, 32'h00a0a0a0);
        rd(32'h14, d); check("frames_rst", d, 32'h0);
        rd(32'h18, d); check("reg6_zero", d, 32'h0);

        // Illegal mode request, then clear the sticky error.
        wr(32'h00, 32'h9, 4'hf);
        rd(32'h10, d); check("status_err", d, 32'h0002_0005);
        wr(32'h10, 32'h0002_0000, 4'hf);
        rd(32'h10, d); check("status_clr", d, 32'h0000_0005);

        // Mode field untouched when sel[0] is clear.
        wr(32'h00, 32'h0000_0201, 4'b0010);
        check("curmode_out", 32'(curmode_o), 32'd2);
        rd(32'h00, d); check("ctrl_rd", d, 32'h0000_0205);

        // Byte lanes on CURPOS, colour upper byte, FBBASE.
        wr(32'h04, 32'hAABBCCDD, 4'b0101);
        rd(32'h04, d); check("curpos_lanes", d, 32'h00BB00DD);
        wr(32'h08, 32'hFF123456, 4'hf);
        rd(32'h08, d); check("curcolor_rd", d, 32'h00123456);
        check("curcolor_out", 32'(curcolor_o), 32'h00123456);
        wr(32'h0C, 32'h8000_1000, 4'hf);
        check("fbbase_out", fb_o, 32'h8000_1000);

`ifdef VGA_MODE_VBLANK_SYNC_EN
        // Switch waits for the vsync falling edge.
        wr(32'h00, 32'h0, 4'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("vb_sel_wait", 32'(sel_o), 32'd5);
            check("vb_hold_wait", 32'(hold_o), 32'd1);
        end
        vs = 1'b0;
        tick(); check("vb_sel_edge", 32'(sel_o), 32'd5);
        tick(); check("vb_sel_new", 32'(sel_o), 32'd0);
        vs = 1'b1;
        repeat (2) tick();
        rd(32'h14, d); check("vb_frames", d, 32'd1);
        // Request while vsync is already low waits for the next falling edge.
        vs = 1'b0;
        repeat (3) tick();
        wr(32'h00, 32'h1, 4'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("vb_low_wait", 32'(sel_o), 32'd0);
        end
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick(); check("vb_low_edge", 32'(sel_o), 32'd0);
        tick(); check("vb_low_new", 32'(sel_o), 32'd1);
        vs = 1'b1;
        rd(32'h14, d); check("vb_frames2", d, 32'd3);
`else
        // Switch blocked by a busy outgoing driver.
        busy[5] = 1'b1;
        wr(32'h00, 32'h3, 4'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("busy_hold", 32'(hold_o), 32'd1);
            check("busy_sel", 32'(sel_o), 32'd5);
        end
        busy[5] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) check("drain_sel", 32'(sel_o), 32'd3);
            if (k <= 4) check("drain_rst_all", 32'(rst_o), 32'h3f);
            else        check("drain_rst_3", 32'(rst_o), 32'h37);
        end

        // Two requests during a switch: last one wins, mode 1 never selected.
        busy[3] = 1'b1;
        wr(32'h00, 32'h0, 4'h1);
        repeat (2) tick();
        busy[3] = 1'b0;
        bus_drive(32'h00, 32'h1, 4'h1, 1'b1);
        tick();
        check("b2b_ack1", 32'(wb.ack), 32'd1);
        bus_drive(32'h00, 32'h2, 4'h1, 1'b1);
        tick();
        check("b2b_ack2", 32'(wb.ack), 32'd1);
        bus_idle();
        saw1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sel_o == 4'd1) saw1 = 1'b1;
        end
        check("mode1_never", 32'(saw1), 32'd0);
        check("two_sel", 32'(sel_o), 32'd2);
        check("two_rst", 32'(rst_o), 32'h3b);

        // Idle driver: new mode two cycles after ack; frames count a vsync pulse.
        wr(32'h00, 32'h0, 4'h1);
        tick(); check("fast_sel_old", 32'(sel_o), 32'd2);
        tick(); check("fast_sel_new", 32'(sel_o), 32'd0);
        vs = 1'b0;
        repeat (3) tick();
        vs = 1'b1;
        rd(32'h14, d); check("frames_one", d, 32'd1);
`endif

        // Reset in the middle of a switch and a bus cycle.
        repeat (6) tick();
        busy = '1;
        wr(32'h00, 32'h4, 4'h1);
        repeat (2) tick();
        check("hold_pre_rst", 32'(hold_o), 32'd1);
        rst_n = 1'b0;
        bus_drive(32'h0C, 32'h12345678, 4'hf, 1'b1);
        tick();
        check("midrst_ack", 32'(wb.ack), 32'd0);
        check("midrst_sel", 32'(sel_o), 32'd5);
        check("midrst_rst", 32'(rst_o), 32'h3f);
        check("midrst_hold", 32'(hold_o), 32'd0);
        check("midrst_fb", fb_o, 32'h0);
        rst_n = 1'b1;
        bus_idle();
        busy = '0;
        repeat (RC + 1) tick();
        check("post_sel", 32'(sel_o), 32'd5);
        check("post_rst", 32'(rst_o), 32'h1f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
